// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// datapath select codes, trap causes and the control-strobe bundle.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_if.sv
// Shared single-port memory handshake between the controller (master)
// and the memory (slave).
interface mips_mc_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_mc_outdec.sv
// Combinational state -> control-strobe decoder. Only the FETCH load strobes
// depend on mem_ready; everything else is a pure function of the state.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.iord      = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = ALU_SRC_B_FOUR;
        o_ctrl.alu_op    = ALU_OP_ADD;
        o_ctrl.pc_src    = PC_SRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = ALU_SRC_B_IMM_SH2;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALU_SRC_B_REG;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REG_DST_RD;
        o_ctrl.mem_to_reg = MEM_TO_REG_ALU;
      end
      S_MEM_ADDR, S_IMM_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALU_SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
        o_ctrl.mem_we  = 1'b0;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
        o_ctrl.mem_we  = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REG_DST_RT;
        o_ctrl.mem_to_reg = MEM_TO_REG_MDR;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = ALU_SRC_B_REG;
        o_ctrl.alu_op        = ALU_OP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write = 1'b1;
        o_ctrl.pc_src   = PC_SRC_JUMP;
      end
      S_IMM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REG_DST_RT;
        o_ctrl.mem_to_reg = MEM_TO_REG_ALU;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait-state timeout and sticky trap.
// Optional performance counters are enabled by defining MIPS_MC_PERF_EN.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 -> PC on completion
// DECODE    | branch target -> ALUOut, dispatch on opcode
// MEM_ADDR  | base + imm for LW/SW
// MEM_READ  | LW data read at ALUOut
// MEM_WB    | MDR -> rt
// MEM_WRITE | SW data write at ALUOut
// EXEC_R    | R-type ALU operation
// R_WB      | ALUOut -> rd
// BRANCH    | compare, conditional PC load
// JUMP      | jump target -> PC
// IMM_EXEC  | reg A + imm
// IMM_WB    | ALUOut -> rt
// TRAP      | fault, all strobes idle until reset
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
`ifdef MIPS_MC_PERF_EN
  ,
  parameter int PERF_W      = 32
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_zero_flag,
  mips_mc_if.master  mem,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic [1:0] o_pc_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_trap,
  output logic [1:0] o_trap_cause,
  output logic [3:0] o_state
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] o_perf_cycles,
  output logic [PERF_W-1:0] o_perf_instrs
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMO_W-1:0] r_wait;
  logic             r_trap;
  logic [1:0]       r_cause;
  logic             r_is_sw;
  logic             w_stall;
  logic             w_tmo;
  logic             w_enter_trap;
  ctrl_t            w_ctrl;
  ctrl_t            w_ctrl_g;

  // zero_flag qualifies pc_write_cond in the datapath, not here
  logic w_unused;
  assign w_unused = i_zero_flag;

  mips_mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign w_stall      = w_ctrl.mem_req & ~mem.mem_ready;
  assign w_tmo        = w_stall && (r_wait == TMO_W'(MEM_TIMEOUT - 1));
  assign w_enter_trap = (w_state_nxt == S_TRAP) && (r_state != S_TRAP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem.mem_ready)  w_state_nxt = S_DECODE;
        else if (w_tmo)     w_state_nxt = S_TRAP;
      end
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     w_state_nxt = S_EXEC_R;
          OP_LW, OP_SW: w_state_nxt = S_MEM_ADDR;
          OP_BEQ:       w_state_nxt = S_BRANCH;
          OP_J:         w_state_nxt = S_JUMP;
          OP_ADDI:      w_state_nxt = S_IMM_EXEC;
          default:      w_state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:   w_state_nxt = S_R_WB;
      S_MEM_ADDR: w_state_nxt = r_is_sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem.mem_ready)  w_state_nxt = S_MEM_WB;
        else if (w_tmo)     w_state_nxt = S_TRAP;
      end
      S_MEM_WRITE: begin
        if (mem.mem_ready)  w_state_nxt = S_FETCH;
        else if (w_tmo)     w_state_nxt = S_TRAP;
      end
      S_IMM_EXEC: w_state_nxt = S_IMM_WB;
      S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_IMM_WB: w_state_nxt = S_FETCH;
      S_TRAP:     w_state_nxt = S_TRAP;
      default:    w_state_nxt = S_TRAP;
    endcase
  end

  // Wait counter runs only while stalled, so it is zero on entry to every access
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_trap  <= 1'b0;
      r_cause <= TRAP_NONE;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_stall ? r_wait + TMO_W'(1) : '0;
      if (w_enter_trap) begin
        r_trap  <= 1'b1;
        r_cause <= (r_state == S_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
      end
      if (r_state == S_DECODE) r_is_sw <= (i_opcode == OP_SW);
    end
  end

  assign w_ctrl_g = i_reset ? w_ctrl : '0;

  assign mem.mem_req      = w_ctrl_g.mem_req;
  assign mem.mem_we       = w_ctrl_g.mem_we;
  assign mem.iord         = w_ctrl_g.iord;
  assign o_ir_write       = w_ctrl_g.ir_write;
  assign o_pc_write       = w_ctrl_g.pc_write;
  assign o_pc_write_cond  = w_ctrl_g.pc_write_cond;
  assign o_pc_src         = w_ctrl_g.pc_src;
  assign o_alu_src_a      = w_ctrl_g.alu_src_a;
  assign o_alu_src_b      = w_ctrl_g.alu_src_b;
  assign o_alu_op         = w_ctrl_g.alu_op;
  assign o_reg_write      = w_ctrl_g.reg_write;
  assign o_reg_dst        = w_ctrl_g.reg_dst;
  assign o_mem_to_reg     = w_ctrl_g.mem_to_reg;
  assign o_trap           = r_trap;
  assign o_trap_cause     = r_cause;
  assign o_state          = r_state;

`ifdef MIPS_MC_PERF_EN
  logic [PERF_W-1:0] r_perf_cycles;
  logic [PERF_W-1:0] r_perf_instrs;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_perf_cycles <= '0;
      r_perf_instrs <= '0;
    end else begin
      if (r_state != S_TRAP)
        r_perf_cycles <= r_perf_cycles + PERF_W'(1);
      if ((w_state_nxt == S_FETCH) && (r_state != S_FETCH))
        r_perf_instrs <= r_perf_instrs + PERF_W'(1);
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_instrs = r_perf_instrs;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl (built with MEM_TIMEOUT=4).
module tb_mips_mc_ctrl;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MADDR = 4'd2;
  localparam logic [3:0] ST_MREAD = 4'd3,  ST_MWB    = 4'd4,  ST_MWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR = 4'd6,  ST_RWB    = 4'd7,  ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP  = 4'd9,  ST_IEXEC  = 4'd10, ST_IWB    = 4'd11;
  localparam logic [3:0] ST_TRAP  = 4'd15;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100, OPC_J = 6'b000010, OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       tb_rst = 1'b0;
  logic       tb_ready = 1'b0;
  logic [5:0] tb_op = 6'd0;
  logic       tb_zero = 1'b0;

  logic       ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, trap;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg, trap_cause;
  logic [3:0] state;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] perf_cycles, perf_instrs;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_irw   = 0;

  mips_mc_if u_mem ();
  assign u_mem.mem_ready = tb_ready;

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .i_clk           (clk),
    .i_reset         (tb_rst),
    .i_opcode        (tb_op),
    .i_zero_flag     (tb_zero),
    .mem             (u_mem),
    .o_ir_write      (ir_write),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_pc_src        (pc_src),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_reg_write     (reg_write),
    .o_reg_dst       (reg_dst),
    .o_mem_to_reg    (mem_to_reg),
    .o_trap          (trap),
    .o_trap_cause    (trap_cause),
    .o_state         (state)
`ifdef MIPS_MC_PERF_EN
    ,
    .o_perf_cycles   (perf_cycles),
    .o_perf_instrs   (perf_instrs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 2 time units after the edge, outputs checked 1 unit later
  task automatic step(input logic rdy, input logic [5:0] op, input logic rst_n);
    @(posedge clk);
    #2;
    tb_ready = rdy;
    tb_op    = op;
    tb_rst   = rst_n;
    #1;
    if (ir_write === 1'b1) n_irw++;
  endtask

  initial begin
    // reset
    step(1'b0, OPC_R, 1'b0);
    step(1'b1, OPC_R, 1'b0);
    chk("rst_state",   32'(state), 32'(ST_FETCH));
    chk("rst_mem_req", 32'(u_mem.mem_req), 32'd0);
    chk("rst_ir_wr",   32'(ir_write), 32'd0);
    chk("rst_pc_wr",   32'(pc_write), 32'd0);
    chk("rst_trap",    32'(trap), 32'd0);
    chk("rst_cause",   32'(trap_cause), 32'd0);
`ifdef MIPS_MC_PERF_EN
    chk("rst_perf_cyc", perf_cycles, 32'd0);
    chk("rst_perf_ins", perf_instrs, 32'd0);
`endif

    // 1: R-type, no wait states
    step(1'b1, OPC_R, 1'b1);
    chk("r_c1_state", 32'(state), 32'(ST_FETCH));
    chk("r_c1_req",   32'(u_mem.mem_req), 32'd1);
    chk("r_c1_iord",  32'(u_mem.iord), 32'd0);
    chk("r_c1_irw",   32'(ir_write), 32'd1);
    chk("r_c1_pcw",   32'(pc_write), 32'd1);
    chk("r_c1_srcb",  32'(alu_src_b), 32'd1);
    chk("r_c1_rw",    32'(reg_write), 32'd0);
    step(1'b1, OPC_R, 1'b1);
    chk("r_c2_state", 32'(state), 32'(ST_DECODE));
    chk("r_c2_srcb",  32'(alu_src_b), 32'd3);
    chk("r_c2_req",   32'(u_mem.mem_req), 32'd0);
    step(1'b1, OPC_R, 1'b1);
    chk("r_c3_state", 32'(state), 32'(ST_EXECR));
    chk("r_c3_srca",  32'(alu_src_a), 32'd1);
    chk("r_c3_aluop", 32'(alu_op), 32'd2);
    chk("r_c3_rw",    32'(reg_write), 32'd0);
    step(1'b1, OPC_R, 1'b1);
    chk("r_c4_state", 32'(state), 32'(ST_RWB));
    chk("r_c4_rw",    32'(reg_write), 32'd1);
    chk("r_c4_dst",   32'(reg_dst), 32'd1);

    // 2: LW with two fetch wait states (7 cycles)
    n_irw = 0;
    step(1'b0, OPC_LW, 1'b1);
    chk("lw_c1_state", 32'(state), 32'(ST_FETCH));
    chk("lw_c1_req",   32'(u_mem.mem_req), 32'd1);
    chk("lw_c1_irw",   32'(ir_write), 32'd0);
    step(1'b0, OPC_LW, 1'b1);
    chk("lw_c2_state", 32'(state), 32'(ST_FETCH));
    chk("lw_c2_pcw",   32'(pc_write), 32'd0);
    step(1'b1, OPC_LW, 1'b1);
    chk("lw_c3_irw",   32'(ir_write), 32'd1);
    step(1'b1, OPC_LW, 1'b1);
    chk("lw_c4_state", 32'(state), 32'(ST_DECODE));
    step(1'b1, OPC_LW, 1'b1);
    chk("lw_c5_state", 32'(state), 32'(ST_MADDR));
    chk("lw_c5_srcb",  32'(alu_src_b), 32'd2);
    step(1'b1, OPC_LW, 1'b1);
    chk("lw_c6_state", 32'(state), 32'(ST_MREAD));
    chk("lw_c6_req",   32'(u_mem.mem_req), 32'd1);
    chk("lw_c6_iord",  32'(u_mem.iord), 32'd1);
    chk("lw_c6_we",    32'(u_mem.mem_we), 32'd0);
    step(1'b1, OPC_BEQ, 1'b1);
    chk("lw_c7_state", 32'(state), 32'(ST_MWB));
    chk("lw_c7_m2r",   32'(mem_to_reg), 32'd1);
    chk("lw_c7_rw",    32'(reg_write), 32'd1);
    chk("lw_c7_dst",   32'(reg_dst), 32'd0);
    chk("lw_irw_cnt",  32'(n_irw), 32'd1);

    // 3: BEQ with zero_flag 1 then 0
    tb_zero = 1'b1;
    step(1'b1, OPC_BEQ, 1'b1);
    chk("beq1_c1_state", 32'(state), 32'(ST_FETCH));
    step(1'b1, OPC_BEQ, 1'b1);
    chk("beq1_c2_state", 32'(state), 32'(ST_DECODE));
    step(1'b1, OPC_BEQ, 1'b1);
    chk("beq1_c3_state", 32'(state), 32'(ST_BRANCH));
    chk("beq1_pcwc",     32'(pc_write_cond), 32'd1);
    chk("beq1_pcsrc",    32'(pc_src), 32'd1);
    chk("beq1_aluop",    32'(alu_op), 32'd1);
    chk("beq1_pcw",      32'(pc_write), 32'd0);
    tb_zero = 1'b0;
    step(1'b1, OPC_BEQ, 1'b1);
    chk("beq0_c1_state", 32'(state), 32'(ST_FETCH));
    step(1'b1, OPC_BEQ, 1'b1);
    step(1'b1, OPC_J, 1'b1);
    chk("beq0_c3_state", 32'(state), 32'(ST_BRANCH));
    chk("beq0_pcwc",     32'(pc_write_cond), 32'd1);
    chk("beq0_pcsrc",    32'(pc_src), 32'd1);

    // J and ADDI
    step(1'b1, OPC_J, 1'b1);
    chk("j_c1_state", 32'(state), 32'(ST_FETCH));
    step(1'b1, OPC_J, 1'b1);
    step(1'b1, OPC_ADDI, 1'b1);
    chk("j_c3_state", 32'(state), 32'(ST_JUMP));
    chk("j_pcw",      32'(pc_write), 32'd1);
    chk("j_pcsrc",    32'(pc_src), 32'd2);
    step(1'b1, OPC_ADDI, 1'b1);
    chk("addi_c1_state", 32'(state), 32'(ST_FETCH));
    step(1'b1, OPC_ADDI, 1'b1);
    step(1'b1, OPC_ADDI, 1'b1);
    chk("addi_c3_state", 32'(state), 32'(ST_IEXEC));
    chk("addi_c3_srcb",  32'(alu_src_b), 32'd2);
    step(1'b1, OPC_BAD, 1'b1);
    chk("addi_c4_state", 32'(state), 32'(ST_IWB));
    chk("addi_c4_rw",    32'(reg_write), 32'd1);
    chk("addi_c4_dst",   32'(reg_dst), 32'd0);
    chk("addi_c4_m2r",   32'(mem_to_reg), 32'd0);

    // 4: illegal opcode
    step(1'b1, OPC_BAD, 1'b1);
    chk("ill_c1_state", 32'(state), 32'(ST_FETCH));
    step(1'b1, OPC_BAD, 1'b1);
    chk("ill_c2_state", 32'(state), 32'(ST_DECODE));
    step(1'b1, OPC_BAD, 1'b1);
    chk("ill_state",    32'(state), 32'(ST_TRAP));
    chk("ill_trap",     32'(trap), 32'd1);
    chk("ill_cause",    32'(trap_cause), 32'd1);
    chk("ill_req",      32'(u_mem.mem_req), 32'd0);
    step(1'b1, OPC_BAD, 1'b1);
    chk("ill_hold",     32'(state), 32'(ST_TRAP));
    chk("ill_hold_req", 32'(u_mem.mem_req), 32'd0);
    chk("ill_hold_irw", 32'(ir_write), 32'd0);
    step(1'b1, OPC_SW, 1'b0);
    chk("ill_rst_req",  32'(u_mem.mem_req), 32'd0);
    step(1'b1, OPC_SW, 1'b0);
    chk("ill_rst_state", 32'(state), 32'(ST_FETCH));
    chk("ill_rst_trap",  32'(trap), 32'd0);
    chk("ill_rst_cause", 32'(trap_cause), 32'd0);

    // 5a: SW timeout with mem_ready held low
    step(1'b1, OPC_SW, 1'b1);
    chk("swt_c1_state", 32'(state), 32'(ST_FETCH));
    step(1'b1, OPC_SW, 1'b1);
    step(1'b1, OPC_SW, 1'b1);
    chk("swt_c3_state", 32'(state), 32'(ST_MADDR));
    for (int k = 0; k < 4; k++) begin
      step(1'b0, OPC_SW, 1'b1);
      chk($sformatf("swt_w%0d_state", k), 32'(state), 32'(ST_MWRITE));
      chk($sformatf("swt_w%0d_we", k),    32'(u_mem.mem_we), 32'd1);
      chk($sformatf("swt_w%0d_iord", k),  32'(u_mem.iord), 32'd1);
    end
    step(1'b0, OPC_SW, 1'b1);
    chk("swt_state", 32'(state), 32'(ST_TRAP));
    chk("swt_trap",  32'(trap), 32'd1);
    chk("swt_cause", 32'(trap_cause), 32'd2);
    chk("swt_we",    32'(u_mem.mem_we), 32'd0);
    step(1'b0, OPC_SW, 1'b0);
    step(1'b0, OPC_SW, 1'b0);

    // 5b: completion on the timeout cycle wins
    step(1'b1, OPC_SW, 1'b1);
    step(1'b1, OPC_SW, 1'b1);
    step(1'b1, OPC_SW, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, OPC_SW, 1'b1);
    step(1'b1, OPC_SW, 1'b1);
    chk("swl_c4_state", 32'(state), 32'(ST_MWRITE));
    chk("swl_c4_we",    32'(u_mem.mem_we), 32'd1);
    step(1'b1, OPC_LW, 1'b1);
    chk("swl_state", 32'(state), 32'(ST_FETCH));
    chk("swl_trap",  32'(trap), 32'd0);

    // 6: reset during MEM_READ wait
    step(1'b1, OPC_LW, 1'b1);
    step(1'b1, OPC_LW, 1'b1);
    step(1'b0, OPC_LW, 1'b1);
    chk("rmr_state", 32'(state), 32'(ST_MREAD));
    chk("rmr_req",   32'(u_mem.mem_req), 32'd1);
    step(1'b0, OPC_LW, 1'b0);
    chk("rmr_rst_req", 32'(u_mem.mem_req), 32'd0);
    step(1'b0, OPC_LW, 1'b0);
    chk("rmr_next_state", 32'(state), 32'(ST_FETCH));
    chk("rmr_next_req",   32'(u_mem.mem_req), 32'd0);
`ifdef MIPS_MC_PERF_EN
    chk("rmr_perf_cyc", perf_cycles, 32'd0);
    chk("rmr_perf_ins", perf_instrs, 32'd0);
`endif
    step(1'b0, OPC_LW, 1'b1);
    chk("rmr_rel_state", 32'(state), 32'(ST_FETCH));
    chk("rmr_rel_req",   32'(u_mem.mem_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
